// File: rtl/bus_io_hub.sv
// Memory-mapped I/O hub: scanned 7-segment display, LED latch, synchronised
// switches and debounced buttons with sticky press flags.
module bus_io_hub #(
   parameter int          DIG_NUM  = 8,
   parameter int          LED_W    = 24,
   parameter int          SW_W     = 24,
   parameter int          BTN_W    = 5,
   parameter int          SCAN_DIV = 20000,
   parameter int          DEB_CYC  = 200000,
   parameter logic [31:0] BASE     = 32'hFFFF_F000
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   input  logic [31:0]        bus_addr,
   input  logic               bus_wen,
   input  logic [31:0]        bus_wdata,
   output logic [31:0]        bus_rdata,
   input  logic [SW_W-1:0]    switches,
   input  logic [BTN_W-1:0]   button,
   output logic [DIG_NUM-1:0] dig_en,
   output logic [7:0]         seg,
   output logic [LED_W-1:0]   led
);
   localparam int DATA_W = 4 * DIG_NUM;
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int IDX_W  = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
   localparam int DEB_W  = $clog2(DEB_CYC);

   logic                w_hit;
   logic                w_wr;
   logic [5:0]          w_off;
   logic                w_unused_ok;
   logic [DATA_W-1:0]   r_dig;
   logic [DIG_NUM-1:0]  r_mask;
   logic                r_blank;
   logic [LED_W-1:0]    r_led;
   logic [SW_W-1:0]     r_sw_s1;
   logic [SW_W-1:0]     r_sw_s2;
   logic [BTN_W-1:0]    r_btn_s1;
   logic [BTN_W-1:0]    r_btn_s2;
   logic [BTN_W-1:0]    r_btn_press;
   logic [BTN_W-1:0]    w_btn_lvl;
   logic [BTN_W-1:0]    w_btn_rise;
   logic [BTN_W-1:0]    w_press_clr;
   logic [SCAN_W-1:0]   r_scan_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic [DIG_NUM-1:0]  r_dig_en;
   logic [7:0]          r_seg;
   logic [7:0]          w_seg_pat;
   logic [DIG_NUM-1:0]  w_blanked;
   logic [3:0]          w_nibs [DIG_NUM];
   logic [3:0]          w_nib;

   assign w_hit       = (bus_addr[31:8] == BASE[31:8]);
   assign w_off       = bus_addr[7:2];
   assign w_wr        = bus_wen & w_hit;
   assign w_press_clr = (w_wr && w_off == 6'h05) ? bus_wdata[BTN_W-1:0] : '0;
   assign w_unused_ok = ^{bus_addr[1:0], bus_wdata};

   always_comb begin
      bus_rdata = '0;
      if (w_hit) begin
         case (w_off)
            6'h00: bus_rdata[DATA_W-1:0] = r_dig;
            6'h01: begin
               bus_rdata[DIG_NUM-1:0] = r_mask;
               bus_rdata[16]          = r_blank;
            end
            6'h02: bus_rdata[LED_W-1:0] = r_led;
            6'h03: bus_rdata[SW_W-1:0]  = r_sw_s2;
            6'h04: bus_rdata[BTN_W-1:0] = w_btn_lvl;
            6'h05: bus_rdata[BTN_W-1:0] = r_btn_press;
            default: ;
         endcase
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         r_dig       <= '0;
         r_mask      <= '1;
         r_blank     <= 1'b0;
         r_led       <= '0;
         r_btn_press <= '0;
         r_sw_s1     <= '0;
         r_sw_s2     <= '0;
         r_btn_s1    <= '0;
         r_btn_s2    <= '0;
      end else begin
         r_sw_s1  <= switches;
         r_sw_s2  <= r_sw_s1;
         r_btn_s1 <= button;
         r_btn_s2 <= r_btn_s1;
         if (w_wr && w_off == 6'h00) r_dig <= bus_wdata[DATA_W-1:0];
         if (w_wr && w_off == 6'h01) begin
            r_mask  <= bus_wdata[DIG_NUM-1:0];
            r_blank <= bus_wdata[16];
         end
         if (w_wr && w_off == 6'h02) r_led <= bus_wdata[LED_W-1:0];
         // A press accepted on the same edge as its clear must not be lost.
         r_btn_press <= (r_btn_press & ~w_press_clr) | w_btn_rise;
      end
   end

   generate
      for (genvar gi = 0; gi < BTN_W; gi++) begin : g_deb
         logic [DEB_W-1:0] r_cnt;
         logic             r_lvl;
         logic             w_flip;
         assign w_flip = (r_btn_s2[gi] != r_lvl) && (r_cnt == DEB_W'(DEB_CYC - 1));
         always_ff @(posedge cpu_clk) begin
            if (cpu_rst) begin
               r_cnt <= '0;
               r_lvl <= 1'b0;
            end else if (r_btn_s2[gi] == r_lvl) begin
               r_cnt <= '0;
            end else if (w_flip) begin
               r_cnt <= '0;
               r_lvl <= ~r_lvl;
            end else begin
               r_cnt <= r_cnt + DEB_W'(1);
            end
         end
         assign w_btn_lvl[gi]  = r_lvl;
         assign w_btn_rise[gi] = w_flip & ~r_lvl;
      end

      for (genvar gi = 0; gi < DIG_NUM; gi++) begin : g_dig
         assign w_nibs[gi] = r_dig[4*gi +: 4];
         if (gi == 0) begin : g_first
            assign w_blanked[gi] = ~r_mask[gi];
         end else begin : g_rest
            // Leading-zero blanking: this digit and everything above it is zero.
            logic w_tail_zero;
            assign w_tail_zero   = (r_dig[DATA_W-1:4*gi] == '0);
            assign w_blanked[gi] = ~r_mask[gi] | (r_blank & w_tail_zero);
         end
      end
   endgenerate

   assign w_nib = w_nibs[r_idx];

   always_comb begin
      w_seg_pat = 8'hFF;
      case (w_nib)
         4'h0: w_seg_pat = 8'hC0;
         4'h1: w_seg_pat = 8'hF9;
         4'h2: w_seg_pat = 8'hA4;
         4'h3: w_seg_pat = 8'hB0;
         4'h4: w_seg_pat = 8'h99;
         4'h5: w_seg_pat = 8'h92;
         4'h6: w_seg_pat = 8'h82;
         4'h7: w_seg_pat = 8'hF8;
         4'h8: w_seg_pat = 8'h80;
         4'h9: w_seg_pat = 8'h90;
         4'hA: w_seg_pat = 8'h88;
         4'hB: w_seg_pat = 8'h83;
         4'hC: w_seg_pat = 8'hC6;
         4'hD: w_seg_pat = 8'hA1;
         4'hE: w_seg_pat = 8'h86;
         default: w_seg_pat = 8'h8E;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
         r_dig_en   <= '1;
         r_seg      <= 8'hFF;
      end else begin
         if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_W'(DIG_NUM - 1)) ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
         end
         if (w_blanked[r_idx]) begin
            r_dig_en <= '1;
            r_seg    <= 8'hFF;
         end else begin
            r_dig_en <= ~(DIG_NUM'(1) << r_idx);
            r_seg    <= w_seg_pat;
         end
      end
   end

   assign dig_en = r_dig_en;
   assign seg    = r_seg;
   assign led    = r_led;

endmodule

// File: tb/tb_bus_io_hub.sv
// Bench for bus_io_hub: directed scenarios plus randomized traffic, all
// checked against a cycle-stepped behavioural model of the register block.
module tb_bus_io_hub;
   localparam int          DIG_NUM  = 4;
   localparam int          LED_W    = 24;
   localparam int          SW_W     = 24;
   localparam int          BTN_W    = 5;
   localparam int          SCAN_DIV = 4;
   localparam int          DEB_CYC  = 3;
   localparam logic [31:0] BASE     = 32'hFFFF_F000;

   logic               clk = 1'b0;
   logic               rst;
   logic [31:0]        addr;
   logic               wen;
   logic [31:0]        wdata;
   logic [31:0]        rdata;
   logic [SW_W-1:0]    sw;
   logic [BTN_W-1:0]   btn;
   logic [DIG_NUM-1:0] dig_en;
   logic [7:0]         seg;
   logic [LED_W-1:0]   led;

   always #5 clk = ~clk;

   bus_io_hub #(
      .DIG_NUM(DIG_NUM), .LED_W(LED_W), .SW_W(SW_W), .BTN_W(BTN_W),
      .SCAN_DIV(SCAN_DIV), .DEB_CYC(DEB_CYC), .BASE(BASE)
   ) dut (
      .cpu_clk(clk), .cpu_rst(rst), .bus_addr(addr), .bus_wen(wen),
      .bus_wdata(wdata), .bus_rdata(rdata), .switches(sw), .button(btn),
      .dig_en(dig_en), .seg(seg), .led(led)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic [15:0] m_dig;
   logic [3:0]  m_mask;
   logic        m_blank;
   logic [23:0] m_led;
   logic [4:0]  m_lvl;
   logic [4:0]  m_press;
   logic [23:0] sw_hist [2];
   logic [4:0]  btn_hist [2];
   logic [4:0]  sync_q [$];
   int          n_edges;
   logic [3:0]  exp_dig_en;
   logic [7:0]  exp_seg;
   logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   function automatic void show(input int k, output logic [3:0] en, output logic [7:0] sg);
      logic [15:0] upper;
      upper = m_dig >> (4 * k);
      if (!m_mask[k] || (m_blank && k > 0 && upper == 16'h0)) begin
         en = 4'hF;
         sg = 8'hFF;
      end else begin
         en = 4'hF & ~(4'h1 << k);
         sg = hex_tab[upper[3:0]];
      end
   endfunction

   function automatic logic [31:0] m_rdata(input logic [31:0] a);
      if (a[31:8] != BASE[31:8]) return 32'h0;
      case (a[7:2])
         6'h00:   return {16'h0, m_dig};
         6'h01:   return {15'h0, m_blank, 12'h0, m_mask};
         6'h02:   return {8'h0, m_led};
         6'h03:   return {8'h0, sw_hist[1]};
         6'h04:   return {27'h0, m_lvl};
         6'h05:   return {27'h0, m_press};
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one rising edge using the inputs presented before it.
   task automatic model_edge();
      logic [4:0] rise;
      logic [4:0] clr;
      logic       all_diff;
      if (rst) begin
         m_dig = 16'h0; m_mask = 4'hF; m_blank = 1'b0; m_led = 24'h0;
         m_lvl = 5'h0; m_press = 5'h0;
         sw_hist[0] = '0; sw_hist[1] = '0; btn_hist[0] = '0; btn_hist[1] = '0;
         sync_q.delete();
         for (int i = 0; i < DEB_CYC; i++) sync_q.push_back(5'h0);
         n_edges = 0; exp_dig_en = 4'hF; exp_seg = 8'hFF;
      end else begin
         show((n_edges / SCAN_DIV) % DIG_NUM, exp_dig_en, exp_seg);
         n_edges++;
         sync_q.push_back(btn_hist[1]);
         void'(sync_q.pop_front());
         rise = 5'h0;
         for (int i = 0; i < BTN_W; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB_CYC; j++)
               if (sync_q[j][i] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) begin
               m_lvl[i] = ~m_lvl[i];
               if (m_lvl[i]) rise[i] = 1'b1;
            end
         end
         clr = 5'h0;
         if (wen && addr[31:8] == BASE[31:8]) begin
            case (addr[7:2])
               6'h00: m_dig = wdata[15:0];
               6'h01: begin m_mask = wdata[3:0]; m_blank = wdata[16]; end
               6'h02: m_led = wdata[23:0];
               6'h05: clr = wdata[4:0];
               default: ;
            endcase
         end
         m_press = (m_press & ~clr) | rise;
         sw_hist[1] = sw_hist[0]; sw_hist[0] = sw;
         btn_hist[1] = btn_hist[0]; btn_hist[0] = btn;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; wen = 1'b1;
      tick();
      wen = 1'b0;
      $display("bus write addr=%h data=%h", a, d);
   endtask

   task automatic test_reset();
      rst = 1'b1; wen = 1'b1; addr = BASE + 32'h8; wdata = 32'hFFFF_FFFF;
      sw = '0; btn = '0;
      tick(); tick();
      n_checks++; if (led !== 24'h0) begin n_fail++; $display("FAIL reset_led: got %h want 000000", led); end
      n_checks++; if (dig_en !== 4'hF) begin n_fail++; $display("FAIL reset_dig_en: got %h want f", dig_en); end
      n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want ff", seg); end
      wen = 1'b0; addr = BASE + 32'h4; #1;
      n_checks++; if (rdata !== 32'h0000_000F) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0000000f", rdata); end
      rst = 1'b0;
      tick();
      n_checks++; if (dig_en !== 4'hE || seg !== 8'hC0) begin n_fail++; $display("FAIL reset_first_slot: got %h/%h want e/c0", dig_en, seg); end
      addr = BASE; #1;
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dig_data: got %h want 0", rdata); end
   endtask

   task automatic test_scan();
      logic [7:0] want_seg [4];
      int prev_k, run_len, runs, wraps, k;
      want_seg = '{8'hF8, 8'h88, 8'hA4, 8'hF9};
      bus_wr(BASE, 32'h0000_12A7);
      tick();
      prev_k = -1; run_len = 0; runs = 0; wraps = 0;
      for (int c = 0; c < 26; c++) begin
         tick();
         k = -1;
         for (int i = 0; i < 4; i++) if (dig_en === (4'hF & ~(4'h1 << i))) k = i;
         n_checks++;
         if (k < 0 || seg !== want_seg[k]) begin n_fail++; $display("FAIL scan_pattern: got %h/%h", dig_en, seg); end
         n_checks++;
         if (dig_en !== exp_dig_en || seg !== exp_seg) begin
            n_fail++; $display("FAIL scan_model: got %h/%h want %h/%h", dig_en, seg, exp_dig_en, exp_seg);
         end
         if (k != prev_k) begin
            if (prev_k >= 0) begin
               if (runs > 0) begin
                  n_checks++; if (run_len != 4) begin n_fail++; $display("FAIL scan_run_len: got %0d want 4", run_len); end
               end
               n_checks++; if (k != (prev_k + 1) % 4) begin n_fail++; $display("FAIL scan_order: got %0d want %0d", k, (prev_k + 1) % 4); end
               if (prev_k == 3 && k == 0) wraps++;
               runs++;
            end
            prev_k = k; run_len = 1;
         end else run_len++;
      end
      n_checks++; if (wraps < 1) begin n_fail++; $display("FAIL scan_wrap: got %0d wraps want >=1", wraps); end
   endtask

   task automatic test_blank();
      int lit;
      bus_wr(BASE, 32'h0000_0005);
      bus_wr(BASE + 32'h4, 32'h0001_000F);
      tick();
      lit = 0;
      for (int c = 0; c < 16; c++) begin
         tick();
         n_checks++;
         if (!((dig_en === 4'hE && seg === 8'h92) || (dig_en === 4'hF && seg === 8'hFF))) begin
            n_fail++; $display("FAIL blank_on: got %h/%h", dig_en, seg);
         end
         if (dig_en === 4'hE) lit++;
      end
      n_checks++; if (lit != 4) begin n_fail++; $display("FAIL blank_on_count: got %0d want 4", lit); end
      bus_wr(BASE + 32'h4, 32'h0000_000F);
      tick();
      lit = 0;
      for (int c = 0; c < 16; c++) begin
         tick();
         n_checks++;
         if (!((dig_en === 4'hE && seg === 8'h92) ||
               ((dig_en === 4'hD || dig_en === 4'hB || dig_en === 4'h7) && seg === 8'hC0))) begin
            n_fail++; $display("FAIL blank_off: got %h/%h", dig_en, seg);
         end
         n_checks++;
         if (dig_en !== exp_dig_en || seg !== exp_seg) begin
            n_fail++; $display("FAIL blank_model: got %h/%h want %h/%h", dig_en, seg, exp_dig_en, exp_seg);
         end
         if (dig_en !== 4'hF) lit++;
      end
      n_checks++; if (lit != 16) begin n_fail++; $display("FAIL blank_off_count: got %0d want 16", lit); end
   endtask

   task automatic test_debounce();
      addr = BASE + 32'h10;
      btn[0] = 1'b1; tick(); tick(); btn[0] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL glitch_lvl: got %h want 0", rdata); end
      end
      addr = BASE + 32'h14; #1;
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL glitch_press: got %h want 0", rdata); end
      addr = BASE + 32'h10;
      btn[0] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_checks++;
         if (rdata !== ((i >= 5) ? 32'h1 : 32'h0)) begin n_fail++; $display("FAIL held_lvl cycle %0d: got %h want %0d", i, rdata, (i >= 5)); end
         n_checks++;
         if (rdata !== m_rdata(addr)) begin n_fail++; $display("FAIL held_model: got %h want %h", rdata, m_rdata(addr)); end
      end
      addr = BASE + 32'h14; #1;
      n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL held_press: got %h want 1", rdata); end
      btn[0] = 1'b0;
      for (int c = 0; c < 8; c++) tick();
   endtask

   task automatic test_press_clear();
      addr = BASE + 32'h14;
      btn[0] = 1'b1;
      for (int i = 1; i <= 4; i++) tick();
      wen = 1'b1; wdata = 32'h1;
      tick();
      wen = 1'b0;
      n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL press_set_wins: got %h want 1", rdata); end
      n_checks++; if (rdata !== m_rdata(addr)) begin n_fail++; $display("FAIL press_set_model: got %h want %h", rdata, m_rdata(addr)); end
      btn[0] = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      bus_wr(BASE + 32'h14, 32'h1);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL press_clear: got %h want 0", rdata); end
   endtask

   task automatic test_bus_decode();
      bus_wr(BASE + 32'h8, 32'hFFFF_FFFF);
      n_checks++; if (led !== 24'hFFFFFF) begin n_fail++; $display("FAIL led_write: got %h want ffffff", led); end
      n_checks++; if (rdata !== 32'h00FF_FFFF) begin n_fail++; $display("FAIL led_read: got %h want 00ffffff", rdata); end
      addr = BASE + 32'h40; #1;
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", rdata); end
      bus_wr(BASE + 32'h40, 32'h5);
      n_checks++; if (led !== 24'hFFFFFF) begin n_fail++; $display("FAIL unmapped_write: got %h want ffffff", led); end
      bus_wr(32'h0000_0008, 32'h5);
      n_checks++; if (led !== 24'hFFFFFF) begin n_fail++; $display("FAIL miss_write: got %h want ffffff", led); end
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL miss_read: got %h want 0", rdata); end
      bus_wr(BASE + 32'hC, 32'h1234_5678);
      addr = BASE + 32'hB; #1;
      n_checks++; if (rdata !== 32'h00FF_FFFF) begin n_fail++; $display("FAIL low_bits_ignored: got %h want 00ffffff", rdata); end
      addr = BASE + 32'hC; sw = 24'hA5A5A5;
      tick();
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL sw_latency1: got %h want 0", rdata); end
      tick();
      n_checks++; if (rdata !== 32'h00A5_A5A5) begin n_fail++; $display("FAIL sw_latency2: got %h want 00a5a5a5", rdata); end
   endtask

   task automatic test_reset_mid();
      int waited;
      waited = 0;
      while (dig_en !== 4'hB && waited < 20) begin tick(); waited++; end
      n_checks++; if (dig_en !== 4'hB) begin n_fail++; $display("FAIL mid_find_slot2: got %h want b", dig_en); end
      rst = 1'b1; wen = 1'b1; addr = BASE + 32'h8; wdata = 32'h3;
      tick();
      rst = 1'b0; wen = 1'b0;
      n_checks++; if (led !== 24'h0) begin n_fail++; $display("FAIL mid_led: got %h want 000000", led); end
      n_checks++; if (dig_en !== 4'hF || seg !== 8'hFF) begin n_fail++; $display("FAIL mid_blank: got %h/%h want f/ff", dig_en, seg); end
      tick();
      n_checks++; if (dig_en !== 4'hE || seg !== 8'hC0) begin n_fail++; $display("FAIL mid_slot0: got %h/%h want e/c0", dig_en, seg); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst   = ($urandom_range(0, 99) == 0);
         wen   = ($urandom_range(0, 2) == 0);
         wdata = $urandom;
         if ($urandom_range(0, 4) == 0) addr = $urandom;
         else addr = BASE | 32'($urandom_range(0, 9) << 2) | 32'($urandom_range(0, 3));
         sw = 24'($urandom);
         if ($urandom_range(0, 5) == 0) btn = btn ^ (5'h1 << $urandom_range(0, 4));
         tick();
         n_checks++;
         if (dig_en !== exp_dig_en || seg !== exp_seg) begin
            n_fail++; $display("FAIL rand_display cycle %0d: got %h/%h want %h/%h", c, dig_en, seg, exp_dig_en, exp_seg);
         end
         n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL rand_led cycle %0d: got %h want %h", c, led, m_led); end
         n_checks++;
         if (rdata !== m_rdata(addr)) begin
            n_fail++; $display("FAIL rand_rdata cycle %0d addr %h: got %h want %h", c, addr, rdata, m_rdata(addr));
         end
      end
      rst = 1'b0; wen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_scan();
      test_blank();
      test_debounce();
      test_press_clear();
      test_bus_decode();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
